// File: rtl/spi_master_drv.sv
// rtl/spi_master_drv.sv - SPI master frame driver: 11-bit command out, optional 8-bit read back
module spi_master_drv #(
    parameter int RD_GAP  = 2,
    parameter int SS_IDLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [10:0] cmd_word,
    output logic        cmd_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        SS_n,
    output logic        MOSI,
    input  logic        MISO
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SHIFT,
        S_WAIT,
        S_CAPTURE,
        S_GAP
    } state_t;

    // Last count value in each timed state; counters restart at 0 on every entry.
    localparam logic [3:0] SHIFT_LAST = 4'd10;
    localparam logic [3:0] CAP_LAST   = 4'd7;
    localparam logic [3:0] WAIT_LAST  = (RD_GAP > 0) ? 4'(RD_GAP - 1) : 4'd0;
    localparam logic [3:0] GAP_LAST   = 4'(SS_IDLE - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [10:0] tx_sreg;
    logic        is_rd;
    logic [7:0]  cap_sreg;
    logic        ss_n_nxt;
    logic        mosi_nxt;
    logic        accept;
    logic        emit_bit;
    logic        cap_done;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = (state == S_IDLE) && cmd_valid;
    // A bit leaves tx_sreg on the START->SHIFT edge and on every SHIFT edge but the last.
    assign emit_bit  = (state == S_START) || ((state == S_SHIFT) && (cnt != SHIFT_LAST));
    assign cap_done  = (state == S_CAPTURE) && (cnt == CAP_LAST);

    // State register and per-state cycle counter, cleared on each state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= 4'd0;
            end else if (state != S_IDLE) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // Next-state decode plus the values SS_n/MOSI take after the coming edge.
    always_comb begin
        state_nxt = state;
        ss_n_nxt  = 1'b1;
        mosi_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_nxt = S_START;
                    ss_n_nxt  = 1'b0;
                end
            end
            S_START: begin
                state_nxt = S_SHIFT;
                ss_n_nxt  = 1'b0;
                mosi_nxt  = tx_sreg[10];
            end
            S_SHIFT: begin
                ss_n_nxt = 1'b0;
                if (cnt == SHIFT_LAST) begin
                    if (!is_rd) begin
                        state_nxt = S_GAP;
                        ss_n_nxt  = 1'b1;
                    end else if (RD_GAP == 0) begin
                        state_nxt = S_CAPTURE;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end else begin
                    mosi_nxt = tx_sreg[10];
                end
            end
            S_WAIT: begin
                ss_n_nxt = 1'b0;
                if (cnt == WAIT_LAST) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                ss_n_nxt = 1'b0;
                if (cnt == CAP_LAST) begin
                    state_nxt = S_GAP;
                    ss_n_nxt  = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Command latch and MSB-first transmit shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sreg <= 11'd0;
            is_rd   <= 1'b0;
        end else if (accept) begin
            tx_sreg <= cmd_word;
            is_rd   <= (cmd_word[10:8] == 3'b111);
        end else if (emit_bit) begin
            tx_sreg <= {tx_sreg[9:0], 1'b0};
        end
    end

    // MISO capture shifter; the final sample goes straight into rd_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_sreg <= 8'd0;
            rd_data  <= 8'd0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= cap_done;
            if (state == S_CAPTURE) begin
                cap_sreg <= {cap_sreg[6:0], MISO};
            end
            if (cap_done) begin
                rd_data <= {cap_sreg[6:0], MISO};
            end
        end
    end

    // Registered serial outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SS_n <= 1'b1;
            MOSI <= 1'b0;
        end else begin
            SS_n <= ss_n_nxt;
            MOSI <= mosi_nxt;
        end
    end

endmodule

// File: tb/tb_spi_master_drv.sv
// tb/tb_spi_master_drv.sv - directed self-checking bench for spi_master_drv
module tb_spi_master_drv;

    localparam int RD_GAP_TB = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [10:0] cmd_word;
    logic        cmd_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        busy;
    logic        ss_n;
    logic        mosi;
    logic        miso = 1'b0;

    logic        cmd_valid2;
    logic [10:0] cmd_word2;
    logic        cmd_ready2;
    logic [7:0]  rd_data2;
    logic        rd_valid2;
    logic        busy2;
    logic        ss_n2;
    logic        mosi2;
    logic        miso2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_master_drv #(.RD_GAP(RD_GAP_TB), .SS_IDLE(2)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_word(cmd_word),
        .cmd_ready(cmd_ready), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
    );

    spi_master_drv #(.RD_GAP(0), .SS_IDLE(1)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_word(cmd_word2),
        .cmd_ready(cmd_ready2), .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2),
        .SS_n(ss_n2), .MOSI(mosi2), .MISO(miso2)
    );

    // Monitors: cycle count, rd_valid pulses, command acceptances.
    int cyc = 0;
    int rv_cnt = 0;
    int acc_cnt = 0;
    int acc_cyc[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) if (rd_valid === 1'b1) rv_cnt++;

    always @(posedge clk) begin
        if (rst === 1'b0 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            acc_cnt++;
            acc_cyc.push_back(cyc);
        end
    end

    // Wrapper model: decodes frames from MOSI and serves reads from a byte memory.
    logic [7:0]  mem [0:255];
    logic [7:0]  cur_addr = 8'd0;
    logic [7:0]  rd_addr  = 8'd0;
    logic [7:0]  rbyte    = 8'd0;
    logic [10:0] frame    = 11'd0;
    logic        rd_frame = 1'b0;
    int          idx      = 0;

    always @(negedge clk) begin
        if (ss_n !== 1'b0) begin
            idx      = 0;
            miso     = 1'b0;
            rd_frame = 1'b0;
        end else begin
            if (idx >= 1 && idx <= 11) frame = {frame[9:0], mosi};
            if (idx == 11) begin
                case (frame[10:8])
                    3'b000: cur_addr = frame[7:0];
                    3'b001: mem[cur_addr] = frame[7:0];
                    3'b110: rd_addr = frame[7:0];
                    3'b111: begin
                        rbyte    = mem[rd_addr];
                        rd_frame = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (rd_frame && idx >= 12 + RD_GAP_TB && idx <= 19 + RD_GAP_TB)
                miso = rbyte[19 + RD_GAP_TB - idx];
            else
                miso = 1'b0;
            idx++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 50), 32'd1);
    endtask

    // Offers one command and returns just after its acceptance edge E0.
    task automatic issue(input logic [10:0] w);
        wait_ready("issue_ready");
        cmd_valid = 1'b1;
        cmd_word  = w;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [10:0] w);
        issue(w);
        wait_ready("frame_done");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic [10:0] w;
        logic [7:0]  b81;
        int rv0;
        int a0;
        int n;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_word = 11'd0;
        cmd_valid2 = 1'b0;
        cmd_word2 = 11'd0;
        miso2 = 1'b0;
        b81 = 8'h81;

        // Reset state
        tick();
        tick();
        chk("rst_ssn", ss_n, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", cmd_ready, 1);

        // Write frame 000_1010_0101: START, 11 bits, 2 GAP cycles
        w = 11'b000_1010_0101;
        issue(w);
        chk("t1_start_ssn", ss_n, 0);
        chk("t1_start_mosi", mosi, 0);
        chk("t1_start_busy", busy, 1);
        chk("t1_start_ready", cmd_ready, 0);
        for (int j = 10; j >= 0; j--) begin
            tick();
            chk("t1_mosi", mosi, w[j]);
            chk("t1_ssn_shift", ss_n, 0);
        end
        tick();
        chk("t1_gap_ssn", ss_n, 1);
        chk("t1_gap_mosi", mosi, 0);
        chk("t1_gap_ready", cmd_ready, 0);
        tick();
        chk("t1_gap2_ssn", ss_n, 1);
        chk("t1_gap2_ready", cmd_ready, 0);
        tick();
        chk("t1_idle_ready", cmd_ready, 1);
        chk("t1_idle_busy", busy, 0);
        chk("t1_no_rv", rv_cnt, 0);

        // Write 0xC3 to address 0x5A, then read it back
        run_frame(11'h05A);
        run_frame(11'h1C3);
        run_frame(11'h65A);
        rv0 = rv_cnt;
        issue(11'h700);
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 21) begin
                chk("t2_e21_rv", rd_valid, 0);
                chk("t2_e21_ssn", ss_n, 0);
            end
            if (k == 22) begin
                chk("t2_e22_rv", rd_valid, 1);
                chk("t2_e22_data", rd_data, 8'hC3);
                chk("t2_e22_ssn", ss_n, 1);
            end
            if (k == 23) begin
                chk("t2_e23_rv", rd_valid, 0);
                chk("t2_e23_ready", cmd_ready, 0);
            end
            if (k == 24) chk("t2_e24_ready", cmd_ready, 1);
        end
        chk("t2_one_pulse", rv_cnt - rv0, 1);

        // Opcode 011: plain 11-bit frame, rd_data untouched
        w = 11'b011_0011_1100;
        issue(w);
        for (int j = 10; j >= 0; j--) begin
            tick();
            chk("t3_mosi", mosi, w[j]);
        end
        tick();
        chk("t3_gap_ssn", ss_n, 1);
        tick();
        tick();
        chk("t3_ready", cmd_ready, 1);
        chk("t3_rd_data", rd_data, 8'hC3);
        chk("t3_no_rv", rv_cnt, 1);

        // cmd_valid held across three write frames
        a0 = acc_cnt;
        cmd_word = 11'h033;
        cmd_valid = 1'b1;
        n = 0;
        while (acc_cnt - a0 < 3 && n < 60) begin
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        chk("t4_acc3", acc_cnt - a0, 3);
        if (acc_cyc.size() >= a0 + 3) begin
            chk("t4_space1", acc_cyc[a0 + 1] - acc_cyc[a0], 15);
            chk("t4_space2", acc_cyc[a0 + 2] - acc_cyc[a0 + 1], 15);
        end else begin
            chk("t4_acc_log", acc_cyc.size(), a0 + 3);
        end
        repeat (20) tick();
        chk("t4_acc_final", acc_cnt - a0, 3);

        // Reset during the 5th SHIFT bit of a read frame
        issue(11'h700);
        for (int k = 1; k <= 5; k++) tick();
        chk("t5_pre_ssn", ss_n, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_ssn", ss_n, 1);
        chk("t5_async_mosi", mosi, 0);
        chk("t5_async_data", rd_data, 8'h00);
        chk("t5_async_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t5_ready", cmd_ready, 1);
        repeat (25) tick();
        chk("t5_no_rv", rv_cnt, 1);
        chk("t5_rd_data", rd_data, 8'h00);
        chk("t5_ssn_idle", ss_n, 1);
        chk("t5_not_busy", busy, 0);

        // RD_GAP=0, SS_IDLE=1 instance reading 0x81; MISO is 1 outside the capture window
        miso2 = 1'b1;
        cmd_word2 = 11'h700;
        cmd_valid2 = 1'b1;
        tick();
        cmd_valid2 = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            tick();
            miso2 = (k >= 12 && k <= 19) ? b81[19 - k] : 1'b1;
            if (k == 12) chk("t6_e12_ssn", ss_n2, 0);
            if (k == 19) begin
                chk("t6_e19_rv", rd_valid2, 0);
                chk("t6_e19_ssn", ss_n2, 0);
            end
            if (k == 20) begin
                chk("t6_e20_rv", rd_valid2, 1);
                chk("t6_e20_data", rd_data2, 8'h81);
                chk("t6_e20_ssn", ss_n2, 1);
                chk("t6_e20_ready", cmd_ready2, 0);
            end
            if (k == 21) begin
                chk("t6_e21_ready", cmd_ready2, 1);
                chk("t6_e21_rv", rd_valid2, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
